// File: rtl/instr_sequencer_if.sv
// Control/status bundle between the picoMIPS decoder side and the instruction sequencer.
interface instr_sequencer_if #(
  parameter int P_SIZE = 5,
  parameter int C_SIZE = 8
);
  logic              ctrlWrite;
  logic              ctrlBranch;
  logic              ctrlBranchZ;
  logic              ctrlMul;
  logic              ctrlWaitSw;
  logic              ctrlHalt;
  logic [P_SIZE-1:0] branchOffset;
  logic              aluZero;
  logic              mulDone;
  logic              switchIn;
  logic [P_SIZE-1:0] pcAddr;
  logic              writeEn;
  logic              mulStart;
  logic              waiting;
  logic              halted;
  logic              mulError;
  logic [C_SIZE-1:0] retired;

  modport master (
    output ctrlWrite, ctrlBranch, ctrlBranchZ, ctrlMul, ctrlWaitSw, ctrlHalt,
    output branchOffset, aluZero, mulDone, switchIn,
    input  pcAddr, writeEn, mulStart, waiting, halted, mulError, retired
  );

  modport slave (
    input  ctrlWrite, ctrlBranch, ctrlBranchZ, ctrlMul, ctrlWaitSw, ctrlHalt,
    input  branchOffset, aluZero, mulDone, switchIn,
    output pcAddr, writeEn, mulStart, waiting, halted, mulError, retired
  );
endinterface

// File: rtl/instr_sequencer.sv
// Multi-cycle picoMIPS sequencer: registered PC, relative branches on a latched zero flag,
// multiplier start/done handshake with timeout, and a press-and-release switch wait.
module instr_sequencer #(
  parameter int P_SIZE      = 5,
  parameter int C_SIZE      = 8,
  parameter int MUL_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             nReset,
  instr_sequencer_if.slave bus
);
  localparam logic [2:0] S_RUN  = 3'd0;
  localparam logic [2:0] S_MUL  = 3'd1;
  localparam logic [2:0] S_SWH  = 3'd2;
  localparam logic [2:0] S_SWL  = 3'd3;
  localparam logic [2:0] S_HALT = 3'd4;
  localparam int         TW     = $clog2(MUL_TIMEOUT + 1);

  logic [2:0]        r_state;
  logic [P_SIZE-1:0] r_pc;
  logic              r_zflag;
  logic              r_mul_start;
  logic              r_mul_err;
  logic [C_SIZE-1:0] r_retired;
  logic [1:0]        r_sw;
  logic [TW-1:0]     r_tmo;

  logic [2:0]        w_next_state;
  logic [P_SIZE-1:0] w_pc_next;
  logic [P_SIZE-1:0] w_pc_inc;
  logic              w_we;
  logic              w_retire;
  logic              w_start;
  logic              w_tmo_err;
  logic              w_taken;
  logic              w_sw_sync;

  assign w_pc_inc  = r_pc + 1'b1;
  assign w_sw_sync = r_sw[1];
  assign w_taken   = bus.ctrlBranch | (bus.ctrlBranchZ & r_zflag);

  always_comb begin
    w_next_state = r_state;
    w_pc_next    = r_pc;
    w_we         = 1'b0;
    w_retire     = 1'b0;
    w_start      = 1'b0;
    w_tmo_err    = 1'b0;
    case (r_state)
      S_RUN: begin
        if (bus.ctrlHalt) begin
          w_next_state = S_HALT;
        end else if (bus.ctrlMul) begin
          w_start      = 1'b1;
          w_next_state = S_MUL;
        end else if (bus.ctrlWaitSw) begin
          w_next_state = S_SWH;
        end else if (bus.ctrlBranch || bus.ctrlBranchZ) begin
          w_pc_next = w_taken ? (r_pc + bus.branchOffset) : w_pc_inc;
          w_retire  = 1'b1;
        end else begin
          w_we      = bus.ctrlWrite;
          w_pc_next = w_pc_inc;
          w_retire  = 1'b1;
        end
      end
      S_MUL: begin
        // completion beats the timeout when both land in the same cycle
        if (bus.mulDone) begin
          w_we         = bus.ctrlWrite;
          w_pc_next    = w_pc_inc;
          w_retire     = 1'b1;
          w_next_state = S_RUN;
        end else if (r_tmo == TW'(MUL_TIMEOUT - 1)) begin
          w_tmo_err    = 1'b1;
          w_next_state = S_HALT;
        end
      end
      S_SWH: begin
        if (w_sw_sync) w_next_state = S_SWL;
      end
      S_SWL: begin
        if (!w_sw_sync) begin
          w_we         = bus.ctrlWrite;
          w_pc_next    = w_pc_inc;
          w_retire     = 1'b1;
          w_next_state = S_RUN;
        end
      end
      S_HALT:  w_next_state = S_HALT;
      default: w_next_state = S_HALT;
    endcase
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      r_state     <= S_RUN;
      r_pc        <= '0;
      r_zflag     <= 1'b0;
      r_mul_start <= 1'b0;
      r_mul_err   <= 1'b0;
      r_retired   <= '0;
      r_sw        <= 2'b00;
      r_tmo       <= '0;
    end else begin
      r_state     <= w_next_state;
      r_pc        <= w_pc_next;
      r_mul_start <= w_start;
      r_sw        <= {r_sw[0], bus.switchIn};
      if (w_we) r_zflag <= bus.aluZero;
      if (w_start) r_tmo <= '0;
      else if (r_state == S_MUL && !bus.mulDone) r_tmo <= r_tmo + 1'b1;
      if (w_tmo_err) r_mul_err <= 1'b1;
      if (w_retire && (r_retired != {C_SIZE{1'b1}})) r_retired <= r_retired + 1'b1;
    end
  end

  assign bus.pcAddr   = r_pc;
  assign bus.writeEn  = w_we & nReset;
  assign bus.mulStart = r_mul_start;
  assign bus.waiting  = (r_state == S_MUL) || (r_state == S_SWH) || (r_state == S_SWL);
  assign bus.halted   = (r_state == S_HALT);
  assign bus.mulError = r_mul_err;
  assign bus.retired  = r_retired;
endmodule

// File: tb/tb_instr_sequencer.sv
// Cycle-table bench for instr_sequencer: each row drives one cycle of inputs and queues the
// outputs expected in that cycle; small retired width exercises saturation.
module tb_instr_sequencer;
  localparam int P = 5;
  localparam int C = 3;
  localparam int T = 15;

  logic clk    = 1'b0;
  logic nReset = 1'b1;
  always #5 clk = ~clk;

  instr_sequencer_if #(.P_SIZE(P), .C_SIZE(C)) bus ();
  instr_sequencer #(.P_SIZE(P), .C_SIZE(C), .MUL_TIMEOUT(T)) dut (
    .clk(clk), .nReset(nReset), .bus(bus)
  );

  typedef struct packed {
    logic wr, br, bz, mul, wsw, hlt;
    logic [4:0] off;
    logic az, md, sw;
  } in_t;
  typedef struct packed {
    logic [4:0] pc;
    logic we, ms, wt, hl, me;
    logic [2:0] ret;
  } obs_t;
  typedef struct packed { in_t i; obs_t e; } row_t;

  obs_t sb[$];
  int checks   = 0;
  int failures = 0;

  function automatic in_t op(int wr, int br, int bz, int mul, int wsw, int hlt,
                             int off, int az, int md, int sw);
    in_t x;
    x.wr = 1'(wr); x.br = 1'(br); x.bz = 1'(bz); x.mul = 1'(mul); x.wsw = 1'(wsw);
    x.hlt = 1'(hlt); x.off = 5'(off); x.az = 1'(az); x.md = 1'(md); x.sw = 1'(sw);
    return x;
  endfunction

  function automatic in_t plain(int wr, int az);
    return op(wr, 0, 0, 0, 0, 0, 0, az, 0, 0);
  endfunction

  // branch rows also request a write with aluZero=1; neither may take effect
  function automatic in_t brn(int uncond, int off);
    return op(1, uncond, 1 - uncond, 0, 0, 0, off, 1, 0, 0);
  endfunction

  function automatic obs_t ex(int pc, int we, int ms, int wt, int hl, int me, int ret);
    obs_t x;
    x.pc = 5'(pc); x.we = 1'(we); x.ms = 1'(ms); x.wt = 1'(wt);
    x.hl = 1'(hl); x.me = 1'(me); x.ret = 3'(ret);
    return x;
  endfunction

  function automatic row_t rw(in_t i, obs_t e);
    row_t x;
    x.i = i; x.e = e;
    return x;
  endfunction

  function automatic obs_t obs();
    obs_t x;
    x.pc = bus.pcAddr; x.we = bus.writeEn; x.ms = bus.mulStart; x.wt = bus.waiting;
    x.hl = bus.halted; x.me = bus.mulError; x.ret = bus.retired;
    return x;
  endfunction

  function automatic string fmt(obs_t x);
    return $sformatf("pc=%0d we=%0b ms=%0b wait=%0b halt=%0b err=%0b ret=%0d",
                     x.pc, x.we, x.ms, x.wt, x.hl, x.me, x.ret);
  endfunction

  task automatic apply(in_t i);
    bus.ctrlWrite = i.wr; bus.ctrlBranch = i.br; bus.ctrlBranchZ = i.bz;
    bus.ctrlMul = i.mul; bus.ctrlWaitSw = i.wsw; bus.ctrlHalt = i.hlt;
    bus.branchOffset = i.off; bus.aluZero = i.az; bus.mulDone = i.md; bus.switchIn = i.sw;
  endtask

  task automatic do_reset();
    nReset = 1'b0;
    apply('0);
    repeat (2) @(posedge clk);
    #1 nReset = 1'b1;
  endtask

  task automatic test_reset();
    obs_t o, e;
    #2 nReset = 1'b0;
    apply(plain(1, 1));
    sb.push_back(ex(0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    e = sb.pop_front(); o = obs(); checks++;
    if (o !== e) begin failures++; $display("FAIL reset: got %s, want %s", fmt(o), fmt(e)); end
    @(posedge clk); #1;
    apply('0);
    nReset = 1'b1;
  endtask

  task automatic test_plain();
    obs_t o, e;
    row_t rows[$];
    for (int k = 0; k < 3; k++) rows.push_back(rw(plain(1, 0), ex(k, 1, 0, 0, 0, 0, k)));
    foreach (rows[k]) begin
      apply(rows[k].i); sb.push_back(rows[k].e);
      @(negedge clk);
      e = sb.pop_front(); o = obs(); checks++;
      if (o !== e) begin failures++; $display("FAIL plain[%0d]: got %s, want %s", k, fmt(o), fmt(e)); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_branch();
    obs_t o, e;
    row_t rows[$];
    rows.push_back(rw(plain(0, 0),  ex(3,  0, 0, 0, 0, 0, 3)));
    rows.push_back(rw(plain(1, 1),  ex(4,  1, 0, 0, 0, 0, 4)));
    rows.push_back(rw(brn(0, 29),   ex(5,  0, 0, 0, 0, 0, 5)));
    rows.push_back(rw(plain(0, 0),  ex(2,  0, 0, 0, 0, 0, 6)));
    rows.push_back(rw(plain(0, 0),  ex(3,  0, 0, 0, 0, 0, 7)));
    rows.push_back(rw(plain(1, 0),  ex(4,  1, 0, 0, 0, 0, 7)));
    rows.push_back(rw(brn(0, 29),   ex(5,  0, 0, 0, 0, 0, 7)));
    rows.push_back(rw(brn(1, 25),   ex(6,  0, 0, 0, 0, 0, 7)));
    rows.push_back(rw(brn(1, 2),    ex(31, 0, 0, 0, 0, 0, 7)));
    rows.push_back(rw(plain(0, 0),  ex(1,  0, 0, 0, 0, 0, 7)));
    foreach (rows[k]) begin
      apply(rows[k].i); sb.push_back(rows[k].e);
      @(negedge clk);
      e = sb.pop_front(); o = obs(); checks++;
      if (o !== e) begin failures++; $display("FAIL branch[%0d]: got %s, want %s", k, fmt(o), fmt(e)); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_saturation();
    obs_t o, e;
    row_t rows[$];
    do_reset();
    for (int k = 0; k < 10; k++) rows.push_back(rw(plain(0, 0), ex(k, 0, 0, 0, 0, 0, (k > 7) ? 7 : k)));
    foreach (rows[k]) begin
      apply(rows[k].i); sb.push_back(rows[k].e);
      @(negedge clk);
      e = sb.pop_front(); o = obs(); checks++;
      if (o !== e) begin failures++; $display("FAIL saturate[%0d]: got %s, want %s", k, fmt(o), fmt(e)); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_mul();
    obs_t o, e;
    row_t rows[$];
    do_reset();
    rows.push_back(rw(brn(1, 7),                          ex(7 - 7, 0, 0, 0, 0, 0, 0)));
    rows.push_back(rw(op(1, 0, 0, 1, 0, 0, 0, 0, 0, 0),   ex(7, 0, 0, 0, 0, 0, 1)));
    rows.push_back(rw(op(1, 0, 0, 1, 0, 0, 0, 0, 0, 0),   ex(7, 0, 1, 1, 0, 0, 1)));
    rows.push_back(rw(op(1, 0, 0, 1, 0, 0, 0, 0, 0, 0),   ex(7, 0, 0, 1, 0, 0, 1)));
    rows.push_back(rw(op(1, 0, 0, 1, 0, 0, 0, 0, 0, 0),   ex(7, 0, 0, 1, 0, 0, 1)));
    rows.push_back(rw(op(1, 0, 0, 1, 0, 0, 0, 1, 1, 0),   ex(7, 1, 0, 1, 0, 0, 1)));
    rows.push_back(rw(op(0, 0, 1, 0, 0, 0, 4, 0, 1, 0),   ex(8, 0, 0, 0, 0, 0, 2)));
    rows.push_back(rw(plain(0, 0),                        ex(12, 0, 0, 0, 0, 0, 3)));
    foreach (rows[k]) begin
      apply(rows[k].i); sb.push_back(rows[k].e);
      @(negedge clk);
      e = sb.pop_front(); o = obs(); checks++;
      if (o !== e) begin failures++; $display("FAIL mul[%0d]: got %s, want %s", k, fmt(o), fmt(e)); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_mul_timeout();
    obs_t o, e;
    row_t rows[$];
    do_reset();
    rows.push_back(rw(op(1, 0, 0, 1, 0, 0, 0, 0, 0, 0), ex(0, 0, 0, 0, 0, 0, 0)));
    for (int k = 1; k <= T; k++)
      rows.push_back(rw(op(1, 0, 0, 1, 0, 0, 0, 0, 0, 0), ex(0, 0, (k == 1) ? 1 : 0, 1, 0, 0, 0)));
    for (int k = 0; k < 3; k++)
      rows.push_back(rw(op(1, 1, 1, 1, 1, 1, 3, 1, 1, 1), ex(0, 0, 0, 0, 1, 1, 0)));
    foreach (rows[k]) begin
      apply(rows[k].i); sb.push_back(rows[k].e);
      @(negedge clk);
      e = sb.pop_front(); o = obs(); checks++;
      if (o !== e) begin failures++; $display("FAIL mul_timeout[%0d]: got %s, want %s", k, fmt(o), fmt(e)); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_mul_done_at_limit();
    obs_t o, e;
    row_t rows[$];
    do_reset();
    rows.push_back(rw(op(1, 0, 0, 1, 0, 0, 0, 0, 0, 0), ex(0, 0, 0, 0, 0, 0, 0)));
    for (int k = 1; k < T; k++)
      rows.push_back(rw(op(1, 0, 0, 1, 0, 0, 0, 0, 0, 0), ex(0, 0, (k == 1) ? 1 : 0, 1, 0, 0, 0)));
    rows.push_back(rw(op(1, 0, 0, 1, 0, 0, 0, 0, 1, 0), ex(0, 1, 0, 1, 0, 0, 0)));
    rows.push_back(rw(plain(0, 0),                      ex(1, 0, 0, 0, 0, 0, 1)));
    foreach (rows[k]) begin
      apply(rows[k].i); sb.push_back(rows[k].e);
      @(negedge clk);
      e = sb.pop_front(); o = obs(); checks++;
      if (o !== e) begin failures++; $display("FAIL mul_limit[%0d]: got %s, want %s", k, fmt(o), fmt(e)); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_wait_sw();
    obs_t o, e;
    row_t rows[$];
    in_t  ws_lo, ws_hi;
    ws_lo = op(1, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    ws_hi = op(1, 0, 0, 0, 1, 0, 0, 0, 0, 1);
    do_reset();
    rows.push_back(rw(brn(1, 9), ex(0, 0, 0, 0, 0, 0, 0)));
    rows.push_back(rw(ws_lo,     ex(9, 0, 0, 0, 0, 0, 1)));
    for (int k = 0; k < 5; k++) rows.push_back(rw(ws_hi, ex(9, 0, 0, 1, 0, 0, 1)));
    rows.push_back(rw(ws_lo,     ex(9, 0, 0, 1, 0, 0, 1)));
    rows.push_back(rw(ws_lo,     ex(9, 0, 0, 1, 0, 0, 1)));
    rows.push_back(rw(ws_lo,     ex(9, 1, 0, 1, 0, 0, 1)));
    rows.push_back(rw(plain(0, 0), ex(10, 0, 0, 0, 0, 0, 2)));
    // second wait, abandoned by reset once the switch has been seen high
    rows.push_back(rw(ws_lo,     ex(11, 0, 0, 0, 0, 0, 3)));
    for (int k = 0; k < 4; k++) rows.push_back(rw(ws_hi, ex(11, 0, 0, 1, 0, 0, 3)));
    foreach (rows[k]) begin
      apply(rows[k].i); sb.push_back(rows[k].e);
      @(negedge clk);
      e = sb.pop_front(); o = obs(); checks++;
      if (o !== e) begin failures++; $display("FAIL wait_sw[%0d]: got %s, want %s", k, fmt(o), fmt(e)); end
      @(posedge clk); #1;
    end
    #2 nReset = 1'b0;
    sb.push_back(ex(0, 0, 0, 0, 0, 0, 0));
    #1;
    e = sb.pop_front(); o = obs(); checks++;
    if (o !== e) begin failures++; $display("FAIL wait_sw_reset: got %s, want %s", fmt(o), fmt(e)); end
  endtask

  task automatic test_halt_mul();
    obs_t o, e;
    row_t rows[$];
    do_reset();
    rows.push_back(rw(op(1, 0, 0, 1, 0, 1, 0, 0, 0, 0), ex(0, 0, 0, 0, 0, 0, 0)));
    for (int k = 0; k < 3; k++)
      rows.push_back(rw(op(1, 0, 0, 1, 0, 1, 0, 0, 1, 0), ex(0, 0, 0, 0, 1, 0, 0)));
    foreach (rows[k]) begin
      apply(rows[k].i); sb.push_back(rows[k].e);
      @(negedge clk);
      e = sb.pop_front(); o = obs(); checks++;
      if (o !== e) begin failures++; $display("FAIL halt_mul[%0d]: got %s, want %s", k, fmt(o), fmt(e)); end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    apply('0);
    test_reset();
    test_plain();
    test_branch();
    test_saturation();
    test_mul();
    test_mul_timeout();
    test_mul_done_at_limit();
    test_wait_sw();
    test_halt_mul();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
